cpu_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute controller for the 4-bit CPU datapath.
//  - Owns the architectural register set (lib_cpu::REGS: a, b, ip, out, cf).
//  - Fetches 8-bit instructions from an external program ROM over a req/ack handshake.
//  - Decodes each instruction into lib_cpu::OPECODE and sequences one register update per instruction.
//  - Sits between the program ROM, the 4-bit input switches and the 4-bit output port.

---
 rtl/cpu_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 4-bit CPU datapath.
// Owns the architectural registers, fetches instructions over a req/ack
// handshake and retires one register update per instruction.
// Optional feature macro: CPU_STEP_EN (adds `step` input and STEP state).
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   run, step          execute enable, single-step pulse (CPU_STEP_EN only)
//   rom_req/addr/ack/data  program ROM fetch handshake
//   in_port, out_port  4-bit input switches / registered output port
//   opcode_o, regs_o   decoded opcode and architectural registers (debug)
//   retire, halted     retire pulse, sticky halt flag

package lib_cpu;
    typedef enum logic [3:0] {
        ADD_A_IMM = 4'h0, MOV_A_B   = 4'h1, IN_A    = 4'h2, MOV_A_IMM = 4'h3,
        MOV_B_A   = 4'h4, ADD_B_IMM = 4'h5, IN_B    = 4'h6, MOV_B_IMM = 4'h7,
        INVALID   = 4'h8, OUT_B     = 4'h9, OUT_IMM = 4'hB, JNC_IMM   = 4'hE,
        JMP_IMM   = 4'hF
    } OPECODE;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] ip;
        logic [3:0] out;
        logic       cf;
    } REGS;

    // Map the instruction opcode field onto OPECODE; holes become INVALID.
    function automatic OPECODE decode(input logic [3:0] f);
        case (f)
            4'h0: return ADD_A_IMM;
            4'h1: return MOV_A_B;
            4'h2: return IN_A;
            4'h3: return MOV_A_IMM;
            4'h4: return MOV_B_A;
            4'h5: return ADD_B_IMM;
            4'h6: return IN_B;
            4'h7: return MOV_B_IMM;
            4'h9: return OUT_B;
            4'hB: return OUT_IMM;
            4'hE: return JNC_IMM;
            4'hF: return JMP_IMM;
            default: return INVALID;
        endcase
    endfunction
endpackage

module cpu_sequencer #(
    parameter int unsigned ROM_AW   = 4,
    parameter logic [3:0]  RESET_IP = 4'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
`ifdef CPU_STEP_EN
    input  logic                step,
`endif
    output logic                rom_req,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic                rom_ack,
    input  logic [7:0]          rom_data,
    input  logic [3:0]          in_port,
    output logic [3:0]          out_port,
    output lib_cpu::OPECODE     opcode_o,
    output lib_cpu::REGS        regs_o,
    output logic                retire,
    output logic                halted
);
    import lib_cpu::*;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
`ifdef CPU_STEP_EN
        , S_STEP
`endif
    } state_t;

    state_t     r_state;
    REGS        r_regs;
    OPECODE     r_opcode;
    logic [3:0] r_imm;
    logic       r_rom_req;
    logic       r_retire;
    logic       r_halted;

    REGS        w_next;
    logic [4:0] w_sum_a;
    logic [4:0] w_sum_b;

    // Register file update for the instruction currently in EXEC.
    // Non-ADD ops clear cf; JNC reads the pre-clear value from r_regs.
    always_comb begin
        w_next    = r_regs;
        w_next.ip = r_regs.ip + 4'd1;
        w_next.cf = 1'b0;
        w_sum_a   = {1'b0, r_regs.a} + {1'b0, r_imm};
        w_sum_b   = {1'b0, r_regs.b} + {1'b0, r_imm};
        case (r_opcode)
            ADD_A_IMM: {w_next.cf, w_next.a} = w_sum_a;
            MOV_A_B:   w_next.a   = r_regs.b;
            IN_A:      w_next.a   = in_port;
            MOV_A_IMM: w_next.a   = r_imm;
            MOV_B_A:   w_next.b   = r_regs.a;
            ADD_B_IMM: {w_next.cf, w_next.b} = w_sum_b;
            IN_B:      w_next.b   = in_port;
            MOV_B_IMM: w_next.b   = r_imm;
            OUT_B:     w_next.out = r_regs.b;
            OUT_IMM:   w_next.out = r_imm;
            JNC_IMM:   if (!r_regs.cf) w_next.ip = r_imm;
            JMP_IMM:   w_next.ip  = r_imm;
            default:   ;
        endcase
    end

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_regs    <= '{a: 4'd0, b: 4'd0, ip: RESET_IP, out: 4'd0, cf: 1'b0};
            r_opcode  <= INVALID;
            r_imm     <= 4'd0;
            r_rom_req <= 1'b0;
            r_retire  <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state   <= S_FETCH;
                        r_rom_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (r_rom_req && rom_ack) begin
                        r_imm     <= rom_data[3:0];
                        r_opcode  <= decode(rom_data[7:4]);
                        r_rom_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_opcode == INVALID) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_regs   <= w_next;
                    r_retire <= 1'b1;
`ifdef CPU_STEP_EN
                    r_state  <= S_STEP;
`else
                    if (run) begin
                        r_state   <= S_FETCH;
                        r_rom_req <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
`endif
                end
`ifdef CPU_STEP_EN
                S_STEP: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                    end else if (step) begin
                        r_state   <= S_FETCH;
                        r_rom_req <= 1'b1;
                    end
                end
`endif
                S_HALT: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_req  = r_rom_req;
    assign rom_addr = ROM_AW'(r_regs.ip);
    assign out_port = r_regs.out;
    assign opcode_o = r_opcode;
    assign regs_o   = r_regs;
    assign retire   = r_retire;
    assign halted   = r_halted;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: expected register snapshots are queued
// as programs are issued; a monitor pops one per retire pulse.
module tb_cpu_sequencer;
    import lib_cpu::*;

`ifdef CPU_STEP_EN
    localparam int STEP_EXTRA = 1;
`else
    localparam int STEP_EXTRA = 0;
`endif
    localparam int G0 = 3 + STEP_EXTRA;
    localparam int G4 = 7 + STEP_EXTRA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       rom_req;
    logic [3:0] rom_addr;
    logic       rom_ack = 1'b0;
    logic [7:0] rom_data = 8'h00;
    logic [3:0] in_port = 4'd0;
    logic [3:0] out_port;
    OPECODE     opcode_o;
    REGS        regs_o;
    logic       retire;
    logic       halted;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .run(run),
`ifdef CPU_STEP_EN
        .step(step),
`endif
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
        .rom_data(rom_data), .in_port(in_port), .out_port(out_port),
        .opcode_o(opcode_o), .regs_o(regs_o), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        REGS r;
        int  gap;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] rom [16];
    int         n_checks = 0;
    int         n_pass = 0;
    int         retire_cnt = 0;
    int         cyc = 0;
    int         ack_delay = 0;
    bit         spurious = 1'b0;
    bit         auto_step = 1'b1;

    task automatic check(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] ip,
                        input logic [3:0] o, input logic cf, input int gap);
        exp_t e;
        e.r.a = a; e.r.b = b; e.r.ip = ip; e.r.out = o; e.r.cf = cf;
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        run = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait until the monitor has seen n retires in total, bounded.
    task automatic wait_retires(input string nm, input int n);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk); #2;
            if (retire_cnt >= n) break;
        end
        check(nm, retire_cnt >= n, 32'(retire_cnt), 32'(n));
    endtask

    // Monitor: one expected snapshot per retire pulse, plus spacing check.
    initial begin
        int last;
        exp_t e;
        last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (retire === 1'b1) begin
                retire_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_retire", 1'b0, 32'(regs_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("retire_regs", regs_o == e.r, 32'(regs_o), 32'(e.r));
                    if (e.gap != 0)
                        check("retire_gap", (cyc - last) == e.gap, 32'(cyc - last), 32'(e.gap));
                end
                last = cyc;
            end
        end
    end

    // ROM responder: ack after ack_delay waiting cycles; optional stray acks while idle.
    initial begin
        bit         pend;
        bit         tgl;
        int         wcnt;
        logic [3:0] pend_addr;
        pend = 1'b0; tgl = 1'b0; wcnt = 0; pend_addr = 4'd0;
        forever begin
            @(negedge clk);
            tgl = ~tgl;
            if (rom_ack) begin
                rom_ack = 1'b0;
                pend    = 1'b0;
            end
            if (!rom_req && pend) begin
                check("req_held_until_ack", rst === 1'b1, 32'(rom_req), 32'd1);
                pend = 1'b0;
            end
            if (rom_req) begin
                if (!pend) begin
                    pend = 1'b1; pend_addr = rom_addr; wcnt = 0;
                end else begin
                    wcnt++;
                    check("addr_stable", rom_addr == pend_addr, 32'(rom_addr), 32'(pend_addr));
                end
                if (wcnt == ack_delay) begin
                    rom_ack  = 1'b1;
                    rom_data = rom[rom_addr];
                end
            end else if (spurious && tgl) begin
                rom_ack  = 1'b1;
                rom_data = 8'h80;
            end
        end
    end

`ifdef CPU_STEP_EN
    always @(negedge clk) if (auto_step) step <= 1'b1; else if (!auto_step && step && 0) step <= 1'b0;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit  ok;
        REGS hold;
        int  base;

        // 1: reset state, then idle with run=0
        fill_rom(8'h80);
        repeat (2) @(negedge clk);
        #1;
        check("rst_rom_req", rom_req == 1'b0, 32'(rom_req), 32'd0);
        check("rst_retire", retire == 1'b0, 32'(retire), 32'd0);
        check("rst_opcode", opcode_o == INVALID, 32'(opcode_o), 32'(INVALID));
        check("rst_regs", regs_o == REGS'(17'd0), 32'(regs_o), 32'd0);
        rst = 1'b0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rom_req !== 1'b0 || regs_o.ip !== 4'd0 || halted !== 1'b0) ok = 1'b0;
        end
        check("idle_hold", ok, 32'(ok), 32'd1);

        // 2: MOV A,1; ADD A,5; MOV B,A; OUT B; JMP 0
        do_reset();
        fill_rom(8'h80);
        rom[0] = 8'h31; rom[1] = 8'h05; rom[2] = 8'h47; rom[3] = 8'h9A; rom[4] = 8'hF0;
        push(4'd1, 4'd0, 4'd1, 4'd0, 1'b0, 0);
        push(4'd6, 4'd0, 4'd2, 4'd0, 1'b0, G0);
        push(4'd6, 4'd6, 4'd3, 4'd0, 1'b0, G0);
        push(4'd6, 4'd6, 4'd4, 4'd6, 1'b0, G0);
        push(4'd6, 4'd6, 4'd0, 4'd6, 1'b0, G0);
        base = retire_cnt;
        run = 1'b1;
        wait_retires("t2_wait4", base + 4);
        check("t2_out_port", out_port == 4'd6, 32'(out_port), 32'd6);
        run = 1'b0;
        wait_retires("t2_wait5", base + 5);
        repeat (5) @(negedge clk);
        check("t2_parked_req", rom_req == 1'b0, 32'(rom_req), 32'd0);
        check("t2_retire_count", retire_cnt == base + 5, 32'(retire_cnt - base), 32'd5);

        // 3: carry and JNC
        do_reset();
        fill_rom(8'h80);
        rom[0] = 8'h33; rom[1] = 8'h0F; rom[2] = 8'hE8; rom[3] = 8'hE8;
        push(4'd3, 4'd0, 4'd1, 4'd0, 1'b0, 0);
        push(4'd2, 4'd0, 4'd2, 4'd0, 1'b1, G0);
        push(4'd2, 4'd0, 4'd3, 4'd0, 1'b0, G0);
        push(4'd2, 4'd0, 4'd8, 4'd0, 1'b0, G0);
        base = retire_cnt;
        run = 1'b1;
        wait_retires("t3_wait3", base + 3);
        run = 1'b0;
        wait_retires("t3_wait4", base + 4);

        // IN/MOV/ADD_B/OUT_IMM coverage
        do_reset();
        fill_rom(8'h80);
        in_port = 4'hC;
        rom[0] = 8'h20; rom[1] = 8'h59; rom[2] = 8'h59; rom[3] = 8'h10;
        rom[4] = 8'h60; rom[5] = 8'h75; rom[6] = 8'hBD;
        push(4'hC, 4'd0, 4'd1, 4'd0, 1'b0, 0);
        push(4'hC, 4'd9, 4'd2, 4'd0, 1'b0, G0);
        push(4'hC, 4'd2, 4'd3, 4'd0, 1'b1, G0);
        push(4'd2, 4'd2, 4'd4, 4'd0, 1'b0, G0);
        push(4'd2, 4'hC, 4'd5, 4'd0, 1'b0, G0);
        push(4'd2, 4'd5, 4'd6, 4'd0, 1'b0, G0);
        push(4'd2, 4'd5, 4'd7, 4'hD, 1'b0, G0);
        base = retire_cnt;
        run = 1'b1;
        wait_retires("t7_wait6", base + 6);
        run = 1'b0;
        wait_retires("t7_wait7", base + 7);
        check("t7_out_port", out_port == 4'hD, 32'(out_port), 32'hD);

        // 4: INVALID opcode at ip=2 halts
        do_reset();
        fill_rom(8'h31);
        rom[0] = 8'h37; rom[1] = 8'h72; rom[2] = 8'h80;
        push(4'd7, 4'd0, 4'd1, 4'd0, 1'b0, 0);
        push(4'd7, 4'd2, 4'd2, 4'd0, 1'b0, G0);
        run = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (halted) break;
        end
        check("t4_halted", halted == 1'b1, 32'(halted), 32'd1);
        check("t4_opcode", opcode_o == INVALID, 32'(opcode_o), 32'(INVALID));
        hold.a = 4'd7; hold.b = 4'd2; hold.ip = 4'd2; hold.out = 4'd0; hold.cf = 1'b0;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rom_req !== 1'b0 || regs_o !== hold || halted !== 1'b1) ok = 1'b0;
        end
        check("t4_frozen", ok, 32'(regs_o), 32'(hold));
        do_reset();
        #1;
        check("t4_rst_clears", halted == 1'b0, 32'(halted), 32'd0);

        // 5: delayed ack with stray acks while rom_req=0
        fill_rom(8'h80);
        rom[0] = 8'h39; rom[1] = 8'h40;
        ack_delay = 4;
        spurious = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_idle_ignores_ack", regs_o == REGS'(17'd0) && !halted, 32'(regs_o), 32'd0);
        push(4'd9, 4'd0, 4'd1, 4'd0, 1'b0, 0);
        push(4'd9, 4'd9, 4'd2, 4'd0, 1'b0, G4);
        base = retire_cnt;
        run = 1'b1;
        wait_retires("t5_wait1", base + 1);
        run = 1'b0;
        wait_retires("t5_wait2", base + 2);
        repeat (6) @(negedge clk);
        check("t5_not_halted", halted == 1'b0, 32'(halted), 32'd0);
        spurious = 1'b0;

        // 6: async reset while rom_req=1
        do_reset();
        fill_rom(8'h80);
        rom[0] = 8'h34;
        push(4'd4, 4'd0, 4'd1, 4'd0, 1'b0, 0);
        base = retire_cnt;
        run = 1'b1;
        wait_retires("t6_wait1", base + 1);
        for (int k = 0; k < 20; k++) begin
            if (rom_req) break;
            @(negedge clk); #2;
        end
        check("t6_req_before_rst", rom_req == 1'b1, 32'(rom_req), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_req_drop", rom_req == 1'b0, 32'(rom_req), 32'd0);
        check("t6_ip_reset", regs_o.ip == 4'd0, 32'(regs_o.ip), 32'd0);
        run = 1'b0;
        ack_delay = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

`ifdef CPU_STEP_EN
        // Single step: one retire per step pulse after the first instruction
        do_reset();
        fill_rom(8'h01);
        auto_step = 1'b0;
        @(negedge clk);
        step = 1'b0;
        push(4'd1, 4'd0, 4'd1, 4'd0, 1'b0, 0);
        push(4'd2, 4'd0, 4'd2, 4'd0, 1'b0, 0);
        push(4'd3, 4'd0, 4'd3, 4'd0, 1'b0, 0);
        push(4'd4, 4'd0, 4'd4, 4'd0, 1'b0, 0);
        base = retire_cnt;
        run = 1'b1;
        wait_retires("step_first", base + 1);
        repeat (3) begin
            repeat (3) @(negedge clk);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (6) @(negedge clk);
        end
        check("step_count", retire_cnt == base + 4, 32'(retire_cnt - base), 32'd4);
        run = 1'b0;
        repeat (3) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size() == 0, 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
